udp_rx: RTL
===========

# udp_rx

Receive-side counterpart of the board's UDP transmit path: parses GMII receive frames (preamble, Ethernet II, IPv4, UDP), filters on the board MAC/IP, streams the UDP payload byte-wise to user logic and checks the Ethernet FCS. Sits between the PHY's GMII RX pins and the application, clocked by the GMII receive clock. It produces a single completion pulse per accepted frame, carrying the payload length and CRC status.

## Interface
- BOARD_MAC, 48'h00_11_22_33_44_55, accepted destination MAC (broadcast ff_ff_ff_ff_ff_ff also accepted)
- BOARD_IP, {8'd192,8'd168,8'd1,8'd10}, accepted destination IPv4 address
- clk  input  1  GMII receive clock (125 MHz); one clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- gmii_rx_dv  input  1  GMII receive data valid
- gmii_rx_er  input  1  GMII receive error
- gmii_rxd  input  8  GMII receive data
- rec_en  output  1  payload byte strobe
- rec_data  output  8  payload byte, valid when rec_en=1
- rec_pkt_done  output  1  one-cycle pulse, frame end for an accepted frame
- rec_byte_num  output  16  payload bytes delivered, valid with rec_pkt_done, held until next done
- rec_crc_ok  output  1  FCS check result, valid with rec_pkt_done, held until next done
- src_mac  output  48  sender MAC of the last accepted frame, updated with rec_pkt_done
- src_ip  output  32  sender IP of the last accepted frame, updated with rec_pkt_done

## Operation
- gmii_rx_dv/er/rxd registered once on entry; the FSM runs on registered copies.
- States: IDLE, PREAMBLE, ETH_HEAD, IP_HEAD, UDP_HEAD, RX_DATA, RX_PAD, DONE, DROP.
- IDLE: first dv=1 with byte 8'h55 -> PREAMBLE; dv=1 with any other byte -> DROP.
- PREAMBLE: count 8'h55; on 8'hD5 after 1..7 preamble bytes -> ETH_HEAD; any other byte or count >7 -> DROP.
- ETH_HEAD (14 bytes): dest MAC must equal BOARD_MAC or all-ones; capture source MAC; EtherType must be 16'h0800; mismatch -> DROP.
- IP_HEAD (20 bytes): byte0 must be 8'h45 (no options); protocol (byte9) must be 8'd17; capture source IP (bytes 12-15); dest IP (bytes 16-19) must equal BOARD_IP; mismatch -> DROP. IP checksum not verified.
- UDP_HEAD (8 bytes): capture length field (bytes 4-5); payload count = length - 8. Length < 8 -> DROP; length = 8 -> RX_PAD directly (zero-byte payload).
- RX_DATA: each byte output with rec_en=1; counter increments; after payload count bytes -> RX_PAD.
- RX_PAD: Ethernet padding and 4 FCS bytes consumed, not output; on dv=0 -> DONE.
- DONE: one cycle; rec_pkt_done=1, rec_byte_num=bytes delivered, rec_crc_ok, src_mac, src_ip updated; -> IDLE.
- DROP: wait for dv=0, -> IDLE; no outputs, no done pulse.
- FCS: CRC-32, reflected polynomial 32'hEDB88320, LSB-first, register init 32'hFFFFFFFF at ETH_HEAD entry; all bytes from dest MAC through last FCS byte folded in; rec_crc_ok=1 iff final register == 32'hDEBB20E3.
- gmii_rx_er=1 with dv=1 in any state other than IDLE/DROP: frame marked errored; if payload not started -> DROP; else continue, rec_crc_ok forced 0 at DONE.
- dv falls during RX_DATA (truncated): -> DONE with rec_byte_num = bytes actually delivered, rec_crc_ok=0.
- dv falls in PREAMBLE/ETH_HEAD/IP_HEAD/UDP_HEAD: -> IDLE, no done pulse.
- Back-to-back frames: IDLE accepts new preamble the cycle after DONE; minimum 1 idle cycle (dv=0) between frames required and sufficient.
- Header byte counter is 6 bits, payload counter 16 bits; UDP length 16'hFFFF handled without wrap (counter compare, not overflow).

## Timing
- Reset: all outputs 0 (rec_en, rec_data, rec_pkt_done, rec_byte_num, rec_crc_ok, src_mac, src_ip); FSM IDLE; CRC register 32'hFFFFFFFF.
- rst mid-frame: FSM to IDLE next cycle; remainder of frame ignored until dv=0 then new preamble (enter DROP semantics via IDLE rule).
- Payload latency: byte on gmii_rxd at edge N appears on rec_data with rec_en=1 at edge N+2.
- rec_pkt_done: asserted 2 cycles after first edge sampling dv=0 at frame end; exactly 1 cycle wide.
- rec_en is never high in the same cycle as rec_pkt_done.
- rec_data holds last value when rec_en=0.

## Test plan
- Valid frame: 7×55, D5, dest MAC 00_11_22_33_44_55, IP 192.168.1.10, UDP length 12, payload DE AD BE EF, 18 pad, correct FCS -> rec_en 4 cycles with DE,AD,BE,EF; rec_pkt_done once; rec_byte_num=4; rec_crc_ok=1; src_ip captured.
- Same frame with one FCS bit flipped -> same 4 payload bytes, rec_pkt_done, rec_crc_ok=0.
- Dest IP 192.168.1.11, then dest MAC 00_11_22_33_44_56, then EtherType 0806 -> no rec_en, no rec_pkt_done for any.
- Broadcast MAC, UDP length 8 -> rec_pkt_done, rec_byte_num=0, rec_crc_ok=1, no rec_en.
- 100-byte payload, dv dropped after 40 payload bytes -> 40 rec_en strobes, rec_pkt_done, rec_byte_num=40, rec_crc_ok=0; next valid frame after 1 idle cycle received correctly.
- rst=1 for one cycle during IP_HEAD -> all outputs 0, no done for that frame; following valid frame received with rec_crc_ok=1.

Source files
------------

// File: rtl/udp_rx.sv
// rtl/udp_rx.sv - GMII receive parser for Ethernet II / IPv4 / UDP with MAC/IP filter and FCS check
module udp_rx #(
  parameter logic [47:0] BOARD_MAC = 48'h00_11_22_33_44_55,
  parameter logic [31:0] BOARD_IP  = {8'd192, 8'd168, 8'd1, 8'd10}
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        gmii_rx_dv,
  input  logic        gmii_rx_er,
  input  logic [7:0]  gmii_rxd,
  output logic        rec_en,
  output logic [7:0]  rec_data,
  output logic        rec_pkt_done,
  output logic [15:0] rec_byte_num,
  output logic        rec_crc_ok,
  output logic [47:0] src_mac,
  output logic [31:0] src_ip
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_PREAMBLE = 4'd1;
  localparam logic [3:0] S_ETH_HEAD = 4'd2;
  localparam logic [3:0] S_IP_HEAD  = 4'd3;
  localparam logic [3:0] S_UDP_HEAD = 4'd4;
  localparam logic [3:0] S_RX_DATA  = 4'd5;
  localparam logic [3:0] S_RX_PAD   = 4'd6;
  localparam logic [3:0] S_DONE     = 4'd7;
  localparam logic [3:0] S_DROP     = 4'd8;

  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
  localparam logic [47:0] MAC_BCAST   = {48{1'b1}};

  logic        dv_r;
  logic        er_r;
  logic [7:0]  rxd_r;
  logic [3:0]  state;
  logic [5:0]  hdr_cnt;
  logic [15:0] pay_cnt;
  logic [15:0] pay_len;
  logic [15:0] udp_len;
  logic [47:0] hdr_sr;
  logic [47:0] hdr_next;
  logic [31:0] crc;
  logic [31:0] crc_next;
  logic        crc_fold;
  logic        err;
  logic [47:0] mac_cap;
  logic [31:0] ip_cap;

  // Reflected CRC-32 update of one byte, LSB first.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] v;
    v = c ^ {24'd0, d};
    for (int i = 0; i < 8; i++) begin
      v = v[0] ? ((v >> 1) ^ CRC_POLY) : (v >> 1);
    end
    return v;
  endfunction

  // Header fields are read from a byte shift register that includes the current byte.
  assign hdr_next = {hdr_sr[39:0], rxd_r};
  assign crc_next = crc_byte(crc, rxd_r);
  assign crc_fold = dv_r && (state == S_ETH_HEAD || state == S_IP_HEAD ||
                             state == S_UDP_HEAD || state == S_RX_DATA || state == S_RX_PAD);

  // Register the GMII pins once; everything downstream works on these copies.
  always_ff @(posedge clk) begin
    if (rst) begin
      dv_r  <= 1'b0;
      er_r  <= 1'b0;
      rxd_r <= 8'd0;
    end else begin
      dv_r  <= gmii_rx_dv;
      er_r  <= gmii_rx_er;
      rxd_r <= gmii_rxd;
    end
  end

  // Frame parser FSM: header checks, payload streaming, FCS accumulation and completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      hdr_cnt      <= 6'd0;
      pay_cnt      <= 16'd0;
      pay_len      <= 16'd0;
      udp_len      <= 16'd0;
      hdr_sr       <= 48'd0;
      crc          <= 32'hFFFFFFFF;
      err          <= 1'b0;
      mac_cap      <= 48'd0;
      ip_cap       <= 32'd0;
      rec_en       <= 1'b0;
      rec_data     <= 8'd0;
      rec_pkt_done <= 1'b0;
      rec_byte_num <= 16'd0;
      rec_crc_ok   <= 1'b0;
      src_mac      <= 48'd0;
      src_ip       <= 32'd0;
    end else begin
      rec_en       <= 1'b0;
      rec_pkt_done <= 1'b0;
      if (dv_r) hdr_sr <= hdr_next;
      if (crc_fold) crc <= crc_next;
      case (state)
        // DONE behaves like IDLE so a preamble arriving right after a frame is not lost.
        S_IDLE, S_DONE: begin
          state <= S_IDLE;
          if (dv_r) begin
            if (rxd_r == 8'h55) begin
              state   <= S_PREAMBLE;
              hdr_cnt <= 6'd1;
              err     <= 1'b0;
            end else begin
              state <= S_DROP;
            end
          end
        end
        S_PREAMBLE: begin
          if (!dv_r) state <= S_IDLE;
          else if (er_r) state <= S_DROP;
          else if (rxd_r == 8'h55) begin
            if (hdr_cnt == 6'd7) state <= S_DROP;
            else hdr_cnt <= hdr_cnt + 6'd1;
          end else if (rxd_r == 8'hD5) begin
            state   <= S_ETH_HEAD;
            hdr_cnt <= 6'd0;
            crc     <= 32'hFFFFFFFF;
          end else state <= S_DROP;
        end
        S_ETH_HEAD: begin
          if (!dv_r) state <= S_IDLE;
          else if (er_r) state <= S_DROP;
          else begin
            hdr_cnt <= hdr_cnt + 6'd1;
            if (hdr_cnt == 6'd5 && hdr_next != BOARD_MAC && hdr_next != MAC_BCAST) state <= S_DROP;
            if (hdr_cnt == 6'd11) mac_cap <= hdr_next;
            if (hdr_cnt == 6'd13) begin
              if (hdr_next[15:0] == 16'h0800) begin
                state   <= S_IP_HEAD;
                hdr_cnt <= 6'd0;
              end else state <= S_DROP;
            end
          end
        end
        S_IP_HEAD: begin
          if (!dv_r) state <= S_IDLE;
          else if (er_r) state <= S_DROP;
          else begin
            hdr_cnt <= hdr_cnt + 6'd1;
            if (hdr_cnt == 6'd0 && rxd_r != 8'h45) state <= S_DROP;
            if (hdr_cnt == 6'd9 && rxd_r != 8'd17) state <= S_DROP;
            if (hdr_cnt == 6'd15) ip_cap <= hdr_next[31:0];
            if (hdr_cnt == 6'd19) begin
              if (hdr_next[31:0] == BOARD_IP) begin
                state   <= S_UDP_HEAD;
                hdr_cnt <= 6'd0;
              end else state <= S_DROP;
            end
          end
        end
        S_UDP_HEAD: begin
          if (!dv_r) state <= S_IDLE;
          else if (er_r) state <= S_DROP;
          else begin
            hdr_cnt <= hdr_cnt + 6'd1;
            if (hdr_cnt == 6'd5) udp_len <= hdr_next[15:0];
            if (hdr_cnt == 6'd7) begin
              pay_cnt <= 16'd0;
              pay_len <= udp_len - 16'd8;
              if (udp_len < 16'd8) state <= S_DROP;
              else if (udp_len == 16'd8) state <= S_RX_PAD;
              else state <= S_RX_DATA;
            end
          end
        end
        S_RX_DATA: begin
          if (!dv_r) begin
            // Truncated frame: report what was delivered, never a good CRC.
            state        <= S_DONE;
            rec_pkt_done <= 1'b1;
            rec_byte_num <= pay_cnt;
            rec_crc_ok   <= 1'b0;
            src_mac      <= mac_cap;
            src_ip       <= ip_cap;
          end else begin
            if (er_r) err <= 1'b1;
            rec_en   <= 1'b1;
            rec_data <= rxd_r;
            pay_cnt  <= pay_cnt + 16'd1;
            if (pay_cnt + 16'd1 == pay_len) state <= S_RX_PAD;
          end
        end
        S_RX_PAD: begin
          if (!dv_r) begin
            state        <= S_DONE;
            rec_pkt_done <= 1'b1;
            rec_byte_num <= pay_cnt;
            rec_crc_ok   <= (crc == CRC_RESIDUE) && !err;
            src_mac      <= mac_cap;
            src_ip       <= ip_cap;
          end else if (er_r) err <= 1'b1;
        end
        S_DROP: begin
          if (!dv_r) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
